// File: rtl/clock_run_ctrl.sv
// Run-control sequencer: decides per cycle whether the controlled clock domain advances.
// Optional pause watchdog enabled by defining CLKRUN_WATCHDOG_EN.
module clock_run_ctrl #(
    parameter int CNT_W       = 32,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             pause,
    input  logic             resume,
    input  logic             step,
    input  logic             abort,
    input  logic [CNT_W-1:0] limit,
    output logic             run_en,
    output logic             stop,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cycles,
    output logic             wdog_to
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_STEP  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] MAX_C = {CNT_W{1'b1}};

    state_t           state_r, state_s;
    logic [CNT_W-1:0] lim_r, lim_s;
    logic [CNT_W-1:0] cycles_r, cycles_s;
    logic             run_en_r, run_en_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             wdog_to_r, wdog_to_s;
    logic             start_acc_s;
    logic             lim_hit_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == MAX_C) begin
            return v;
        end else begin
            return v + ONE_C;
        end
    endfunction

    // The cycle now running is the last one allowed by the captured limit.
    assign lim_hit_s = (lim_r != {CNT_W{1'b0}}) && (cycles_r == (lim_r - ONE_C));

`ifdef CLKRUN_WATCHDOG_EN
    localparam int WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST_C = WDOG_W'(WDOG_CYCLES - 1);

    logic [WDOG_W-1:0] wdog_cnt_r, wdog_cnt_s;
    logic              wdog_exp_s;

    assign wdog_exp_s = (wdog_cnt_r == WDOG_LAST_C);

    // Watchdog counter: counts consecutive PAUSE cycles, cleared whenever PAUSE is left or entered.
    always_comb begin
        wdog_cnt_s = {WDOG_W{1'b0}};
        if ((state_r == ST_PAUSE) && (state_s == ST_PAUSE)) begin
            wdog_cnt_s = wdog_cnt_r + {{(WDOG_W-1){1'b0}}, 1'b1};
        end else begin
            wdog_cnt_s = {WDOG_W{1'b0}};
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt_r <= {WDOG_W{1'b0}};
        end else begin
            wdog_cnt_r <= wdog_cnt_s;
        end
    end
`else
    logic wdog_exp_s;
    assign wdog_exp_s = 1'b0;
`endif

    // State and output registers; outputs are flopped copies of next-cycle values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            lim_r     <= {CNT_W{1'b0}};
            cycles_r  <= {CNT_W{1'b0}};
            run_en_r  <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            wdog_to_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            lim_r     <= lim_s;
            cycles_r  <= cycles_s;
            run_en_r  <= run_en_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            wdog_to_r <= wdog_to_s;
        end
    end

    // Next-state logic; priority abort > limit reached > pause, resume > step.
    always_comb begin
        state_s     = state_r;
        start_acc_s = 1'b0;
        done_s      = 1'b0;
        wdog_to_s   = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s     = ST_RUN;
                    start_acc_s = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (lim_hit_s) begin
                    state_s = ST_DONE;
                    done_s  = 1'b1;
                end else if (pause) begin
                    state_s = ST_PAUSE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (resume) begin
                    state_s = ST_RUN;
                end else if (step) begin
                    state_s = ST_STEP;
                end else if (wdog_exp_s) begin
                    state_s   = ST_IDLE;
                    wdog_to_s = 1'b1;
                end else begin
                    state_s = ST_PAUSE;
                end
            end
            ST_STEP: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (lim_hit_s) begin
                    state_s = ST_DONE;
                    done_s  = 1'b1;
                end else begin
                    state_s = ST_PAUSE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs and the captured limit.
    always_comb begin
        run_en_s = (state_s == ST_RUN) || (state_s == ST_STEP);
        busy_s   = (state_s == ST_RUN) || (state_s == ST_STEP) || (state_s == ST_PAUSE);
        lim_s    = lim_r;
        cycles_s = cycles_r;
        if (start_acc_s) begin
            lim_s    = limit;
            cycles_s = {CNT_W{1'b0}};
        end else if (run_en_r) begin
            lim_s    = lim_r;
            cycles_s = sat_inc(cycles_r);
        end else begin
            lim_s    = lim_r;
            cycles_s = cycles_r;
        end
    end

    assign run_en  = run_en_r;
    assign stop    = ~run_en_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign cycles  = cycles_r;
    assign wdog_to = wdog_to_r;

endmodule

// File: tb/tb_clock_run_ctrl.sv
// Directed self-checking bench for clock_run_ctrl (32-bit and 4-bit counter instances).
module tb_clock_run_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0, pause = 1'b0, resume = 1'b0, step = 1'b0, abort = 1'b0;
    logic [31:0] limit = 32'd0;
    logic        run_en, stop, busy, done, wdog_to;
    logic [31:0] cycles;

    logic        start4 = 1'b0;
    logic        zero4 = 1'b0;
    logic [3:0]  limit4 = 4'd0;
    logic        run_en4, stop4, busy4, done4, wdog_to4;
    logic [3:0]  cycles4;

    int n_checks = 0;
    int n_fail   = 0;
    int run_cnt;
    int done_cnt;

    always #5 clk = ~clk;

    clock_run_ctrl #(.CNT_W(32), .WDOG_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .resume(resume),
        .step(step), .abort(abort), .limit(limit), .run_en(run_en), .stop(stop),
        .busy(busy), .done(done), .cycles(cycles), .wdog_to(wdog_to)
    );

    clock_run_ctrl #(.CNT_W(4), .WDOG_CYCLES(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .pause(zero4), .resume(zero4),
        .step(zero4), .abort(zero4), .limit(limit4), .run_en(run_en4), .stop(stop4),
        .busy(busy4), .done(done4), .cycles(cycles4), .wdog_to(wdog_to4)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset values
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_run_en", run_en, 32'd0);
        check_eq("rst_stop", stop, 32'd1);
        check_eq("rst_busy", busy, 32'd0);
        check_eq("rst_cycles", cycles, 32'd0);
        check_eq("rst_done", done, 32'd0);
        check_eq("rst_wdog", wdog_to, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // 1: asynchronous reset in the middle of an unlimited run
        @(negedge clk) begin limit = 32'd0; start = 1'b1; end
        @(negedge clk) start = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("t1_running", run_en, 32'd1);
        check_eq("t1_cycles_pre", cycles, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t1_run_en", run_en, 32'd0);
        check_eq("t1_stop", stop, 32'd1);
        check_eq("t1_cycles", cycles, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check_eq("t1_idle_busy", busy, 32'd0);
        check_eq("t1_idle_run_en", run_en, 32'd0);

        // 2: bounded run of 5 cycles
        limit = 32'd5; start = 1'b1;
        @(negedge clk) start = 1'b0;
        check_eq("t2_latency", run_en, 32'd1);
        check_eq("t2_stop_inv", stop, 32'd0);
        limit = 32'd2;
        run_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (run_en) run_cnt++;
            if (done) done_cnt++;
            if (i < 9) @(negedge clk);
        end
        check_eq("t2_run_cycles", run_cnt, 32'd5);
        check_eq("t2_done_pulses", done_cnt, 32'd1);
        check_eq("t2_cycles", cycles, 32'd5);
        check_eq("t2_stop", stop, 32'd1);
        check_eq("t2_busy", busy, 32'd0);

        // 4: pause in the final limit cycle loses to limit reached
        limit = 32'd4; start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("t4_cycles_pre", cycles, 32'd3);
        pause = 1'b1;
        @(negedge clk) pause = 1'b0;
        check_eq("t4_done", done, 32'd1);
        check_eq("t4_busy", busy, 32'd0);
        check_eq("t4_run_en", run_en, 32'd0);
        check_eq("t4_cycles", cycles, 32'd4);
        @(negedge clk);
        check_eq("t4_done_once", done, 32'd0);

        // 3: unlimited run, pause, three steps, resume, abort
        limit = 32'd0; start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (9) @(negedge clk);
        pause = 1'b1;
        @(negedge clk) pause = 1'b0;
        check_eq("t3_paused_run_en", run_en, 32'd0);
        check_eq("t3_paused_busy", busy, 32'd1);
        check_eq("t3_paused_cycles", cycles, 32'd10);
        @(negedge clk);
        check_eq("t3_cycles_held", cycles, 32'd10);
        for (int s = 0; s < 3; s++) begin
            step = 1'b1;
            @(negedge clk) step = 1'b0;
            check_eq("t3_step_run_en", run_en, 32'd1);
            @(negedge clk);
            check_eq("t3_step_after", run_en, 32'd0);
        end
        check_eq("t3_step_cycles", cycles, 32'd13);
        resume = 1'b1;
        @(negedge clk) resume = 1'b0;
        check_eq("t3_resumed", run_en, 32'd1);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        check_eq("t3_abort_busy", busy, 32'd0);
        check_eq("t3_abort_run_en", run_en, 32'd0);
        check_eq("t3_abort_cycles", cycles, 32'd18);
        check_eq("t3_abort_done", done, 32'd0);

        // 6: pause watchdog
        start = 1'b1;
        @(negedge clk) begin start = 1'b0; pause = 1'b1; end
        @(negedge clk) pause = 1'b0;
        check_eq("t6_paused", busy, 32'd1);
        repeat (7) @(negedge clk);
        check_eq("t6_before_busy", busy, 32'd1);
        check_eq("t6_before_wdog", wdog_to, 32'd0);
        @(negedge clk);
`ifdef CLKRUN_WATCHDOG_EN
        check_eq("t6_wdog_pulse", wdog_to, 32'd1);
        check_eq("t6_wdog_busy", busy, 32'd0);
`else
        check_eq("t6_no_wdog", wdog_to, 32'd0);
        check_eq("t6_still_paused", busy, 32'd1);
`endif
        check_eq("t6_cycles_kept", cycles, 32'd1);
        @(negedge clk);
        check_eq("t6_wdog_low", wdog_to, 32'd0);

        // 5: 4-bit counter saturates in an unlimited run
        limit4 = 4'd0; start4 = 1'b1;
        @(negedge clk) start4 = 1'b0;
        repeat (14) @(negedge clk);
        check_eq("t5_cycles_14", cycles4, 32'd14);
        repeat (5) @(negedge clk);
        check_eq("t5_sat", cycles4, 32'd15);
        check_eq("t5_run_en", run_en4, 32'd1);
        check_eq("t5_done", done4, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
